// File: rtl/dmadd_driver_if.sv
// Host-side and MAC-side bus bundle for dmadd_driver: command, MAC load/run and result handshakes.
// The driver uses the slave modport; the host/MAC side uses master.
interface dmadd_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [3:0]  cmd_base;
   logic        mac_load;
   logic        mac_run;
   logic [1:0]  mac_insn;
   logic [3:0]  mac_index;
   logic [3:0]  mac_data;
   logic [15:0] mac_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        busy;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_base, mac_out, res_ready,
      input  cmd_ready, mac_load, mac_run, mac_insn, mac_index, mac_data,
             res_valid, res_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_base, mac_out, res_ready,
      output cmd_ready, mac_load, mac_run, mac_insn, mac_index, mac_data,
             res_valid, res_data, busy
   );
endinterface

// File: rtl/dmadd_driver.sv
// DMADD command sequencer: four nibble loads, run pulse, fixed-latency capture, held result.
// Optional operand cache enabled by defining DMADD_DRV_OPCACHE_EN.
module dmadd_driver #(
   parameter int unsigned RUN_LAT = 4
) (
   input  logic           clk,
   input  logic           rst,
   dmadd_driver_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, RESULT} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RUN_LAT - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [1:0]  op_q, op_nxt;
   logic [7:0]  a_q, a_nxt;
   logic [7:0]  b_q, b_nxt;
   logic [3:0]  base_q, base_nxt;
   logic        cmd_ready_q, cmd_ready_nxt;
   logic        mac_load_q, mac_load_nxt;
   logic        mac_run_q, mac_run_nxt;
   logic [1:0]  mac_insn_q, mac_insn_nxt;
   logic [3:0]  mac_index_q, mac_index_nxt;
   logic [3:0]  mac_data_q, mac_data_nxt;
   logic        res_valid_q, res_valid_nxt;
   logic [15:0] res_data_q, res_data_nxt;
   logic        cache_hit;

   function automatic logic [3:0] nibble(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] k);
      case (k)
         2'd0:    return a[3:0];
         2'd1:    return a[7:4];
         2'd2:    return b[3:0];
         default: return b[7:4];
      endcase
   endfunction

`ifdef DMADD_DRV_OPCACHE_EN
   logic [7:0] cache_a, cache_b;
   logic [3:0] cache_base;
   logic       cache_vld;

   // Snapshot taken only when the fourth nibble has been written, so an aborted load never hits.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_vld <= 1'b0;
      end else if (state == LOAD && cnt == 4'd4) begin
         cache_vld <= 1'b1;
      end
   end

   // NOTE: the operand copies carry no reset; they are ignored until cache_vld is set.
   always_ff @(posedge clk) begin
      if (!rst && state == LOAD && cnt == 4'd4) begin
         cache_a    <= a_q;
         cache_b    <= b_q;
         cache_base <= base_q;
      end
   end

   assign cache_hit = cache_vld && (bus.cmd_a == cache_a) && (bus.cmd_b == cache_b)
                      && (bus.cmd_base == cache_base);
`else
   assign cache_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
      state_nxt     = state;
      cnt_nxt       = cnt;
      op_nxt        = op_q;
      a_nxt         = a_q;
      b_nxt         = b_q;
      base_nxt      = base_q;
      mac_load_nxt  = 1'b0;
      mac_run_nxt   = 1'b0;
      mac_insn_nxt  = 2'b00;
      mac_index_nxt = 4'h0;
      mac_data_nxt  = 4'h0;
      res_data_nxt  = res_data_q;

      case (state)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               op_nxt   = bus.cmd_op;
               a_nxt    = bus.cmd_a;
               b_nxt    = bus.cmd_b;
               base_nxt = bus.cmd_base;
               if (cache_hit) begin
                  state_nxt    = RUN;
                  mac_run_nxt  = 1'b1;
                  mac_insn_nxt = bus.cmd_op;
               end else begin
                  state_nxt     = LOAD;
                  cnt_nxt       = 4'd1;
                  mac_load_nxt  = 1'b1;
                  mac_index_nxt = bus.cmd_base;
                  mac_data_nxt  = bus.cmd_a[3:0];
               end
            end
         end
         LOAD: begin
            // cnt is the index of the nibble being registered for the next cycle.
            if (cnt == 4'd4) begin
               state_nxt    = RUN;
               mac_run_nxt  = 1'b1;
               mac_insn_nxt = op_q;
            end else begin
               mac_load_nxt  = 1'b1;
               mac_index_nxt = base_q + cnt;
               mac_data_nxt  = nibble(a_q, b_q, cnt[1:0]);
               cnt_nxt       = cnt + 4'd1;
            end
         end
         RUN: begin
            state_nxt = WAIT;
            cnt_nxt   = 4'd0;
         end
         WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_nxt    = RESULT;
               res_data_nxt = bus.mac_out;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         RESULT: begin
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      cmd_ready_nxt = (state_nxt == IDLE);
      res_valid_nxt = (state_nxt == RESULT);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of order.
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         op_q        <= 2'b00;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         base_q      <= 4'h0;
         cmd_ready_q <= 1'b0;
         mac_load_q  <= 1'b0;
         mac_run_q   <= 1'b0;
         mac_insn_q  <= 2'b00;
         mac_index_q <= 4'h0;
         mac_data_q  <= 4'h0;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'h0000;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         op_q        <= op_nxt;
         a_q         <= a_nxt;
         b_q         <= b_nxt;
         base_q      <= base_nxt;
         cmd_ready_q <= cmd_ready_nxt;
         mac_load_q  <= mac_load_nxt;
         mac_run_q   <= mac_run_nxt;
         mac_insn_q  <= mac_insn_nxt;
         mac_index_q <= mac_index_nxt;
         mac_data_q  <= mac_data_nxt;
         res_valid_q <= res_valid_nxt;
         res_data_q  <= res_data_nxt;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mac_load  = mac_load_q;
   assign bus.mac_run   = mac_run_q;
   assign bus.mac_insn  = mac_insn_q;
   assign bus.mac_index = mac_index_q;
   assign bus.mac_data  = mac_data_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmadd_driver.sv
// Directed bench for dmadd_driver: per-cycle traces compared against hand-derived bus sequences.
module tb_dmadd_driver;
   localparam int LAT = 4;
   localparam int TRACE_LEN = 16;

`ifdef DMADD_DRV_OPCACHE_EN
   localparam int HIT_LOADS = 0;
   localparam int HIT_SAMPLE = 1 + LAT;
`else
   localparam int HIT_LOADS = 4;
   localparam int HIT_SAMPLE = 5 + LAT;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   // Per-cycle row: {mac_load, mac_index, mac_data, mac_run, mac_insn, res_valid}
   logic [12:0] t_row [1:TRACE_LEN];
   logic [15:0] t_res;

   dmadd_driver_if bus ();

   dmadd_driver #(.RUN_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected row for cycle c after acceptance; idx/dat hold the four nibbles, first in [15:12].
   function automatic logic [12:0] exp_row(input int c, input int nload, input logic [15:0] idx,
                                           input logic [15:0] dat, input logic [1:0] op);
      logic       ld, rn, rv;
      logic [3:0] ix, dt;
      logic [1:0] in;
      ld = (c >= 1) && (c <= nload);
      ix = 4'h0;
      dt = 4'h0;
      if (ld) begin
         ix = 4'((idx >> (4 * (4 - c))) & 16'h000F);
         dt = 4'((dat >> (4 * (4 - c))) & 16'h000F);
      end
      rn = (c == nload + 1);
      in = rn ? op : 2'b00;
      rv = (c >= nload + 2 + LAT);
      return {ld, ix, dt, rn, in, rv};
   endfunction

   // Offers one command at the current negedge and records TRACE_LEN cycles with res_ready low.
   // mac_out carries 0x1234 only in cycle 'sample'; any other capture cycle gives 0xF0xx.
   task automatic issue_and_trace(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] base, input int sample);
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_base  = base;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= TRACE_LEN; c++) begin
         bus.mac_out = (c == sample) ? 16'h1234 : (16'hF000 | 16'(c));
         t_row[c] = {bus.mac_load, bus.mac_index, bus.mac_data, bus.mac_run, bus.mac_insn,
                     bus.res_valid};
         @(negedge clk);
      end
      t_res = bus.res_data;
   endtask

   task automatic release_result();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic compare_trace(input string name, input int nload, input logic [15:0] idx,
                                input logic [15:0] dat, input logic [1:0] op);
      logic [12:0] want;
      for (int c = 1; c <= TRACE_LEN; c++) begin
         want = exp_row(c, nload, idx, dat, op);
         checks++;
         if (t_row[c] !== want) begin
            failures++;
            $display("FAIL %s cycle %0d: row got %h want %h", name, c, t_row[c], want);
         end
      end
      checks++;
      if (t_res !== 16'h1234) begin
         failures++;
         $display("FAIL %s res_data: got %h want 1234", name, t_res);
      end
   endtask

   task automatic check_after_release(input string name);
      checks++;
      if ({bus.res_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
         failures++;
         $display("FAIL %s release: {res_valid,cmd_ready,busy} got %b want 010", name,
                  {bus.res_valid, bus.cmd_ready, bus.busy});
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b11;
      bus.cmd_a     = 8'hFF;
      bus.cmd_b     = 8'hFF;
      bus.cmd_base  = 4'h3;
      bus.mac_out   = 16'hFFFF;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.cmd_ready, bus.mac_load, bus.mac_run, bus.mac_insn, bus.mac_index, bus.mac_data,
              bus.res_valid, bus.res_data, bus.busy} !== 31'd0) begin
            failures++;
            $display("FAIL reset cycle %0d: outputs not all zero (ready=%b load=%b run=%b busy=%b res=%h)",
                     i, bus.cmd_ready, bus.mac_load, bus.mac_run, bus.busy, bus.res_data);
         end
      end
      rst = 1'b0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.busy, bus.mac_load} !== 3'b100) begin
         failures++;
         $display("FAIL reset release: {cmd_ready,busy,mac_load} got %b want 100",
                  {bus.cmd_ready, bus.busy, bus.mac_load});
      end
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset no-accept: busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_basic();
      issue_and_trace(2'b01, 8'hA5, 8'h3C, 4'h0, 5 + LAT);
      compare_trace("basic", 4, 16'h0123, 16'h5AC3, 2'b01);
      release_result();
      check_after_release("basic");
   endtask

   task automatic test_wrap();
      issue_and_trace(2'b10, 8'h21, 8'h43, 4'hE, 5 + LAT);
      compare_trace("wrap", 4, 16'hEF01, 16'h1234, 2'b10);
      release_result();
      check_after_release("wrap");
   endtask

   task automatic test_backpressure();
      issue_and_trace(2'b11, 8'h5A, 8'hC3, 4'h4, 5 + LAT);
      compare_trace("bp", 4, 16'h4567, 16'hA53C, 2'b11);
      for (int i = 0; i < 7; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_a     = 8'(i);
         bus.mac_out   = 16'hBEEF ^ 16'(i * 257);
         checks++;
         if ({bus.res_valid, bus.cmd_ready, bus.mac_load, bus.mac_run, bus.res_data} !==
             {4'b1000, 16'h1234}) begin
            failures++;
            $display("FAIL bp hold %0d: valid=%b ready=%b load=%b run=%b data=%h want 1,0,0,0,1234",
                     i, bus.res_valid, bus.cmd_ready, bus.mac_load, bus.mac_run, bus.res_data);
         end
         @(negedge clk);
      end
      release_result();
      bus.cmd_valid = 1'b0;
      check_after_release("bp");
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL bp no-accept: busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_load();
      int bad;
      bus.cmd_op    = 2'b00;
      bus.cmd_a     = 8'h77;
      bus.cmd_b     = 8'h11;
      bus.cmd_base  = 4'h8;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.mac_load, bus.mac_index, bus.mac_data} !== 9'b1_1001_0111) begin
         failures++;
         $display("FAIL midrst load2: {load,index,data} got %b want 110010111",
                  {bus.mac_load, bus.mac_index, bus.mac_data});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.mac_load, bus.mac_index, bus.mac_data, bus.cmd_ready, bus.busy} !== 11'd0) begin
         failures++;
         $display("FAIL midrst reset: load=%b index=%h data=%h ready=%b busy=%b want all 0",
                  bus.mac_load, bus.mac_index, bus.mac_data, bus.cmd_ready, bus.busy);
      end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.mac_run || bus.res_valid || bus.mac_load) bad++;
      end
      checks++;
      if (bad != 0 || bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst after: stray cycles got %0d want 0, cmd_ready got %b want 1",
                  bad, bus.cmd_ready);
      end
   endtask

   task automatic test_cache();
      issue_and_trace(2'b01, 8'hA5, 8'h3C, 4'h0, 5 + LAT);
      compare_trace("cache_first", 4, 16'h0123, 16'h5AC3, 2'b01);
      release_result();
      // Offered in the very cycle cmd_ready returns: back-to-back with the previous handshake.
      issue_and_trace(2'b01, 8'hA5, 8'h3C, 4'h0, HIT_SAMPLE);
      compare_trace("cache_repeat", HIT_LOADS, 16'h0123, 16'h5AC3, 2'b01);
      release_result();
      issue_and_trace(2'b01, 8'hA5, 8'h3D, 4'h0, 5 + LAT);
      compare_trace("cache_miss", 4, 16'h0123, 16'h5AD3, 2'b01);
      release_result();
      check_after_release("cache");
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_a     = 8'h00;
      bus.cmd_b     = 8'h00;
      bus.cmd_base  = 4'h0;
      bus.mac_out   = 16'h0000;
      bus.res_ready = 1'b0;
      rst           = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_reset_mid_load();
      test_cache();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
